// File: rtl/csa_pkg.sv
// Shared elaboration-time helpers for the pipelined carry-skip adder:
// block count, block-to-stage distribution and parameter legality.
package csa_pkg;

    localparam int CSA_WIDTH_MIN = 4;
    localparam int CSA_WIDTH_MAX = 128;
    localparam int CSA_BLOCK_MIN = 2;

    function automatic int num_blocks(input int width, input int block);
        return (width + block - 1) / block;
    endfunction

    // Earlier stages absorb the extra block when blocks do not divide evenly.
    function automatic int stage_first_block(input int width, input int block,
                                             input int stages, input int stage);
        int nb;
        int base;
        int rem;
        nb   = num_blocks(width, block);
        base = nb / stages;
        rem  = nb % stages;
        return stage * base + ((stage < rem) ? stage : rem);
    endfunction

    function automatic int block_stage(input int width, input int block,
                                       input int stages, input int blk);
        int st;
        st = 0;
        for (int s = 0; s < stages; s++) begin
            if (blk >= stage_first_block(width, block, stages, s)) st = s;
        end
        return st;
    endfunction

    function automatic int stage_lo_bit(input int width, input int block,
                                        input int stages, input int stage);
        return stage_first_block(width, block, stages, stage) * block;
    endfunction

    function automatic int stage_hi_bit(input int width, input int block,
                                        input int stages, input int stage);
        int hi;
        hi = stage_first_block(width, block, stages, stage + 1) * block;
        if (hi > width) hi = width;
        return hi - 1;
    endfunction

    function automatic bit params_ok(input int width, input int block, input int stages);
        return (width >= CSA_WIDTH_MIN) && (width <= CSA_WIDTH_MAX) &&
               (block >= CSA_BLOCK_MIN) && (block <= width) &&
               (stages >= 1) && (stages <= num_blocks(width, block));
    endfunction

endpackage

// File: rtl/csa_skip_block.sv
// One carry-skip block: ripple sum plus a bypass that forwards the block
// carry-in when every bit position propagates.
module csa_skip_block #(
    parameter int BW = 4
) (
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic          ci,
    output logic [BW-1:0] s,
    output logic          p,
    output logic          co
);
    logic [BW-1:0] prop;
    logic          rip_co;

    always_comb begin
        logic c;
        prop = a ^ b;
        c    = ci;
        s    = '0;
        for (int i = 0; i < BW; i++) begin
            s[i] = prop[i] ^ c;
            c    = (a[i] & b[i]) | (prop[i] & c);
        end
        rip_co = c;
    end

    assign p  = &prop;
    assign co = p ? ci : rip_co;

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-skip adder/subtractor with valid/ready flow control.
// Each stage resolves its share of skip blocks and forwards the carry onward.
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NB   = num_blocks(WIDTH, BLOCK);
    localparam int LAST = STAGES - 1;

    if (!params_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_params
        $error("csa_pipe_adder: illegal WIDTH/BLOCK/STAGES combination");
    end

    logic [STAGES-1:0] v_q, v_d, c_q, c_d;
    logic [STAGES-1:0] adv, src_v, src_c, nxt_c;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic [WIDTH-1:0]  blk_sum;

    // Carries chain through per-block locals so each link is its own net.
    for (genvar k = 0; k < NB; k++) begin : g_blk
        localparam int LO = k * BLOCK;
        localparam int BW = ((WIDTH - LO) < BLOCK) ? (WIDTH - LO) : BLOCK;
        localparam int ST = block_stage(WIDTH, BLOCK, STAGES, k);
        logic ci;
        logic co;
        logic unused_p;

        if (k == stage_first_block(WIDTH, BLOCK, STAGES, ST)) begin : g_entry
            assign ci = src_c[ST];
        end else begin : g_chain
            assign ci = g_blk[k-1].co;
        end

        csa_skip_block #(.BW(BW)) u_blk (
            .a  (src_a[ST][LO+BW-1:LO]),
            .b  (src_b[ST][LO+BW-1:LO]),
            .ci (ci),
            .s  (blk_sum[LO+BW-1:LO]),
            .p  (unused_p),
            .co (co)
        );
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = stage_lo_bit(WIDTH, BLOCK, STAGES, s);
        localparam int HI = stage_hi_bit(WIDTH, BLOCK, STAGES, s);
        localparam int LB = stage_first_block(WIDTH, BLOCK, STAGES, s + 1) - 1;
        localparam logic [WIDTH-1:0] ONES = '1;
        localparam logic [WIDTH-1:0] MASK = (ONES >> (WIDTH - 1 - HI)) & (ONES << LO);

        if (s == 0) begin : g_head
            assign src_v[s] = in_valid;
            assign src_a[s] = a;
            assign src_b[s] = sub ? ~b : b;
            assign src_c[s] = sub | cin;
            assign src_s[s] = '0;
        end else begin : g_body
            assign src_v[s] = v_q[s-1];
            assign src_a[s] = a_q[s-1];
            assign src_b[s] = b_q[s-1];
            assign src_c[s] = c_q[s-1];
            assign src_s[s] = s_q[s-1];
        end

        assign nxt_s[s] = (src_s[s] & ~MASK) | (blk_sum & MASK);
        assign nxt_c[s] = g_blk[LB].co;
    end

    always_comb begin
        logic go;
        go = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            go     = !v_q[s] || go;
            adv[s] = go;
        end
    end

    assign in_ready = rst_n && adv[0];

    always_comb begin
        v_d = v_q;
        c_d = c_q;
        a_d = a_q;
        b_d = b_q;
        s_d = s_q;
        for (int s = 0; s < STAGES; s++) begin
            if (adv[s]) begin
                v_d[s] = src_v[s];
                if (src_v[s]) begin
                    c_d[s] = nxt_c[s];
                    a_d[s] = src_a[s];
                    b_d[s] = src_b[s];
                    s_d[s] = nxt_s[s];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            a_q <= '{default: '0};
            b_q <= '{default: '0};
            s_q <= '{default: '0};
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];
    assign ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                       (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: directed corner cases, backpressure and reset on a
// 32-bit instance, plus a concurrent random sweep on a 13/4/3 instance.
module tb_csa_pipe_adder;
    localparam int W  = 32;
    localparam int ST = 2;
    localparam int N13 = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, in_valid, in_ready, cin_i, sub_i, out_valid, out_ready, cout, ovf;
    logic [W-1:0]  a_i, b_i, sum;
    logic          rst13_n, iv13, ir13, cin13, sub13, ov13, or13, cout13, ovf13;
    logic [12:0]   a13, b13, sum13;

    int n_checks = 0;
    int n_fail   = 0;

    csa_pipe_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    csa_pipe_adder #(.WIDTH(13), .BLOCK(4), .STAGES(3)) u_dut13 (
        .clk(clk), .rst_n(rst13_n), .in_valid(iv13), .in_ready(ir13),
        .a(a13), .b(b13), .cin(cin13), .sub(sub13), .out_valid(ov13),
        .out_ready(or13), .sum(sum13), .cout(cout13), .ovf(ovf13)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain WIDTH+1-bit arithmetic.
    function automatic logic [33:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
        logic [31:0] ye;
        logic [32:0] t;
        ye = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, ye} + {32'd0, (s ? 1'b1 : c)};
        return {((x[31] == ye[31]) && (t[31] != x[31])), t[32], t[31:0]};
    endfunction

    function automatic logic [14:0] ref13(input logic [12:0] x, input logic [12:0] y,
                                          input logic c, input logic s);
        logic [12:0] ye;
        logic [13:0] t;
        ye = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, ye} + {13'd0, (s ? 1'b1 : c)};
        return {((x[12] == ye[12]) && (t[12] != x[12])), t[13], t[12:0]};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [12:0] pick13();
        case ($urandom_range(0, 7))
            0: return 13'h0000;
            1: return 13'h1FFF;
            2: return 13'h0FFF;
            3: return 13'h1000;
            default: return 13'($urandom);
        endcase
    endfunction

    // Scoreboards sampled on the falling edge, where handshakes are settled.
    logic [33:0] q32 [$];
    logic [14:0] q13 [$];
    int          n_out32 = 0;
    int          n_out13 = 0;
    bit          stall32 = 0;
    bit          stall13 = 0;
    logic [34:0] hold32;
    logic [15:0] hold13;

    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst_n) begin
            stall32 = 0;
        end else begin
            if (stall32) check_eq("hold32", 64'({out_valid, ovf, cout, sum}), 64'(hold32));
            if (out_valid && out_ready) begin
                check_eq("q_nonempty32", 64'(q32.size() != 0), 64'd1);
                if (q32.size() != 0) begin
                    e = q32.pop_front();
                    check_eq("data32", 64'({ovf, cout, sum}), 64'(e));
                end
                n_out32++;
            end
            stall32 = out_valid && !out_ready;
            hold32  = {1'b1, ovf, cout, sum};
            if (in_valid && in_ready) q32.push_back(ref32(a_i, b_i, cin_i, sub_i));
        end
    end

    always @(negedge clk) begin
        logic [14:0] e;
        if (!rst13_n) begin
            stall13 = 0;
        end else begin
            if (stall13) check_eq("hold13", 64'({ov13, ovf13, cout13, sum13}), 64'(hold13));
            if (ov13 && or13) begin
                check_eq("q_nonempty13", 64'(q13.size() != 0), 64'd1);
                if (q13.size() != 0) begin
                    e = q13.pop_front();
                    check_eq("data13", 64'({ovf13, cout13, sum13}), 64'(e));
                end
                n_out13++;
            end
            stall13 = ov13 && !or13;
            hold13  = {1'b1, ovf13, cout13, sum13};
            if (iv13 && ir13) q13.push_back(ref13(a13, b13, cin13, sub13));
        end
    end

    task automatic directed(input logic [31:0] da, input logic [31:0] db, input logic dc,
                            input logic ds, input logic [31:0] es, input logic ec, input logic eo);
        int lat;
        lat = -1;
        @(posedge clk); #1;
        a_i = da; b_i = db; cin_i = dc; sub_i = ds; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check_eq("dir_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a_i = $urandom; b_i = $urandom;
        for (int k = 1; k <= 8 && lat < 0; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                check_eq("dir_sum", 64'(sum), 64'(es));
                check_eq("dir_cout", 64'(cout), 64'(ec));
                check_eq("dir_ovf", 64'(ovf), 64'(eo));
            end
        end
        check_eq("dir_latency", 64'(lat), 64'(ST));
    endtask

    task automatic drain32();
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 30 && (q32.size() != 0 || out_valid); i++) @(negedge clk);
        check_eq("drain32", 64'(q32.size()), 64'd0);
    endtask

    bit done13 = 0;

    initial begin
        int sent;
        rst13_n = 1'b1; iv13 = 1'b0; or13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0; sub13 = 1'b0;
        #3 rst13_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst13_n = 1'b1;
        sent = 0;
        while (sent < N13) begin
            @(posedge clk); #1;
            iv13  = ($urandom_range(0, 4) != 0);
            or13  = ($urandom_range(0, 3) != 0);
            a13   = pick13();
            b13   = pick13();
            cin13 = 1'($urandom);
            sub13 = 1'($urandom);
            @(negedge clk);
            if (iv13 && ir13) sent++;
        end
        @(posedge clk); #1;
        iv13 = 1'b0; or13 = 1'b1;
        for (int i = 0; i < 50 && (q13.size() != 0 || ov13); i++) @(negedge clk);
        done13 = 1;
    end

    initial begin
        int acc, sent, base, ghosts;
        bit saw_low;
        logic [31:0] va [8];
        logic [31:0] vb [8];

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        #3 rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_sum", 64'(sum), 64'd0);
        check_eq("rst_cout", 64'(cout), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_in_ready", 64'(in_ready), 64'd1);

        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        directed(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
        directed(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Full-rate streaming.
        acc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a_i = pick32(); b_i = pick32();
            cin_i = 1'($urandom); sub_i = 1'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
        end
        check_eq("throughput", 64'(acc), 64'd10);
        drain32();

        // Backpressure: eight back-to-back inputs, output stalled for cycles 3..6.
        for (int i = 0; i < 8; i++) begin
            va[i] = pick32();
            vb[i] = pick32();
        end
        sent = 0; saw_low = 0; base = n_out32;
        for (int cyc = 0; cyc < 40 && (n_out32 - base) < 8; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                a_i = va[sent]; b_i = vb[sent]; cin_i = sent[0]; sub_i = sent[1];
            end
            @(negedge clk);
            if (sent < 8 && !in_ready) saw_low = 1;
            if (in_valid && in_ready) sent++;
        end
        check_eq("bp_in_ready_low", 64'(saw_low), 64'd1);
        check_eq("bp_sent", 64'(sent), 64'd8);
        check_eq("bp_count", 64'(n_out32 - base), 64'd8);
        drain32();

        // Reset with two transactions in flight.
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1; a_i = $urandom; b_i = $urandom;
        @(negedge clk);
        @(posedge clk); #1;
        a_i = $urandom; b_i = $urandom;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        q32.delete();
        base = n_out32;
        @(negedge clk);
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        ghosts = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        check_eq("no_ghost", 64'(ghosts), 64'd0);
        check_eq("no_ghost_out", 64'(n_out32 - base), 64'd0);
        directed(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a_i = pick32(); b_i = pick32();
            cin_i = 1'($urandom); sub_i = 1'($urandom);
        end
        drain32();

        for (int i = 0; i < 60000 && !done13; i++) @(negedge clk);
        check_eq("sweep13_done", 64'(done13), 64'd1);
        check_eq("sweep13_count", 64'(n_out13), 64'(N13));
        check_eq("sweep13_drain", 64'(q13.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
